// File: rtl/arbiter8_rr_if.sv
// Request/grant bundle for the 8-way round-robin arbiter; all signals active-low except oGntId/oValid/oTimeout.
// master drives requests and enable, slave (the arbiter) drives the registered grant outputs.
interface arbiter8_rr_if;
  logic       iEI;
  logic [7:0] iReq;
  logic [7:0] oGnt;
  logic [2:0] oGntId;
  logic       oValid;
  logic       oEO;
  logic       oTimeout;

  modport master (
    output iEI, iReq,
    input  oGnt, oGntId, oValid, oEO, oTimeout
  );

  modport slave (
    input  iEI, iReq,
    output oGnt, oGntId, oValid, oEO, oTimeout
  );
endinterface

// File: rtl/arbiter8_rr.sv
// 8-way descending round-robin arbiter, registered outputs, 1-cycle grant latency; no preemption, grantee holds until it drops.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (forced release after 16 held cycles).
module arbiter8_rr (
  input  logic          iClk,
  input  logic          iRst_n,
  arbiter8_rr_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_REL   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       valid_q, valid_d;
  logic       eo_q, eo_d;
  logic [2:0] last_q, last_d;
  logic       timeout_d;

  logic       pick_found;
  logic [2:0] pick_id;
  logic [2:0] probe;
  logic       idle_quiet;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       timeout_q;
`endif

  // Search starts one below the last grantee and walks downward with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = 3'd0;
    probe      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      probe = last_q - 3'(k);
      if (!pick_found && !bus.iReq[probe]) begin
        pick_found = 1'b1;
        pick_id    = probe;
      end
    end
  end

  assign idle_quiet = !bus.iEI && (bus.iReq == 8'hFF);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    eo_d      = eo_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!bus.iEI && pick_found) begin
          state_d  = ST_GRANT;
          gnt_id_d = pick_id;
          gnt_d    = ~(8'd1 << pick_id);
          valid_d  = 1'b1;
          eo_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = 4'd0;
`endif
        end else begin
          eo_d = !idle_quiet;
        end
      end
      ST_GRANT: begin
        if (bus.iReq[gnt_id_q] || bus.iEI) begin
          state_d = ST_REL;
          gnt_d   = 8'hFF;
          valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == 4'hF) begin
          state_d   = ST_REL;
          gnt_d     = 8'hFF;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      ST_REL: begin
        // Releasing grantee becomes lowest priority for the next search.
        state_d = ST_IDLE;
        last_d  = gnt_id_q;
        eo_d    = !idle_quiet;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'hFF;
        valid_d = 1'b0;
        eo_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 8'hFF;
      gnt_id_q <= 3'd0;
      valid_q  <= 1'b0;
      eo_q     <= 1'b1;
      last_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      valid_q  <= valid_d;
      eo_q     <= eo_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      cnt_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.oTimeout = timeout_q;
`else
  assign bus.oTimeout = 1'b0;
`endif

  assign bus.oGnt   = gnt_q;
  assign bus.oGntId = gnt_id_q;
  assign bus.oValid = valid_q;
  assign bus.oEO    = eo_q;

endmodule

// File: tb/tb_arbiter8_rr.sv
// Bench for arbiter8_rr: cycle model of the arbitration rules checked every cycle, plus directed literal checks.
module tb_arbiter8_rr;

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  arbiter8_rr_if bus();

  arbiter8_rr dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who holds the grant, whether this cycle is the release cycle, and how long it was held.
  int holder   = -1;
  bit in_rel   = 1'b0;
  int m_last   = 0;
  int held     = 0;
  bit m_eo     = 1'b1;
  bit m_tout   = 1'b0;
  bit m_live   = 1'b0;
  bit found;
  int cand;

  always @(posedge iClk) begin
    if (!iRst_n) begin
      holder = -1; in_rel = 1'b0; m_last = 0; held = 0;
      m_eo = 1'b1; m_tout = 1'b0; m_live = 1'b1;
    end else begin
      m_tout = 1'b0;
      if (in_rel) begin
        in_rel = 1'b0;
        m_last = holder;
        holder = -1;
        m_eo   = !(!bus.iEI && bus.iReq == 8'hFF);
      end else if (holder >= 0) begin
        if (bus.iReq[holder] || bus.iEI) in_rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
        else if (held == 16) begin in_rel = 1'b1; m_tout = 1'b1; end
`endif
        else held++;
      end else if (!bus.iEI && bus.iReq != 8'hFF) begin
        found = 1'b0;
        for (int d = 1; d <= 8; d++) begin
          cand = (m_last - d + 8) % 8;
          if (!found && !bus.iReq[cand]) begin found = 1'b1; holder = cand; end
        end
        held = 1;
        m_eo = 1'b1;
      end else begin
        m_eo = !(!bus.iEI && bus.iReq == 8'hFF);
      end
    end
  end

  bit         e_v;
  logic [7:0] e_gnt;
  always @(negedge iClk) begin
    if (m_live) begin
      e_v   = (holder >= 0) && !in_rel;
      e_gnt = e_v ? ~(8'd1 << holder) : 8'hFF;
      chk("model_gnt", bus.oGnt, e_gnt);
      chk("model_valid", bus.oValid, e_v);
      chk("model_eo", bus.oEO, m_eo);
      chk("model_timeout", bus.oTimeout, m_tout);
      if (e_v) chk("model_gnt_id", bus.oGntId, holder);
    end
  end

  task automatic step();
    @(negedge iClk);
  endtask

  task automatic wait_grant(output int id);
    int n;
    n = 0;
    step();
    while (!bus.oValid && n < 8) begin
      step();
      n++;
    end
    chk("wait_grant", bus.oValid, 1'b1);
    id = bus.oGntId;
  endtask

  int         gid;
  int         exp_seq [4] = '{7, 0, 7, 0};
  logic [7:0] base;
  int         run, touts, tout_at;
  bit         broken, regrant;

  initial begin
    bus.iEI  = 1'b1;
    bus.iReq = 8'hFF;
    iRst_n   = 1'b0;
    step(); step();
    chk("rst_gnt", bus.oGnt, 8'hFF);
    chk("rst_gnt_id", bus.oGntId, 3'd0);
    chk("rst_valid", bus.oValid, 1'b0);
    chk("rst_eo", bus.oEO, 1'b1);
    chk("rst_timeout", bus.oTimeout, 1'b0);

    // First search after reset starts at bit 7, then skips down past the releaser.
    iRst_n = 1'b1; bus.iEI = 1'b0; bus.iReq = 8'b01010010;
    step();
    chk("v1_gnt_id", bus.oGntId, 3'd7);
    chk("v1_gnt", bus.oGnt, 8'b01111111);
    bus.iReq = 8'b11010010;
    step();
    chk("v1_rel_valid", bus.oValid, 1'b0);
    chk("v1_rel_gnt", bus.oGnt, 8'hFF);
    step();
    chk("v1_idle_valid", bus.oValid, 1'b0);
    step();
    chk("v1_gnt_id5", bus.oGntId, 3'd5);
    chk("v1_gnt5", bus.oGnt, 8'b11011111);

    // Enable withdrawn mid-grant of requester 5.
    bus.iEI = 1'b1;
    step();
    chk("ei_rel_valid", bus.oValid, 1'b0);
    bus.iReq = 8'h00;
    repeat (10) step();
    chk("ei_valid", bus.oValid, 1'b0);
    chk("ei_gnt", bus.oGnt, 8'hFF);
    chk("ei_eo", bus.oEO, 1'b1);
    bus.iEI = 1'b0; bus.iReq = 8'hFF;
    step();
    chk("eo_low", bus.oEO, 1'b0);

    // Reset in the middle of a grant to requester 3.
    bus.iReq = 8'b11110111;
    step();
    chk("g3_gnt_id", bus.oGntId, 3'd3);
    chk("g3_valid", bus.oValid, 1'b1);
    iRst_n = 1'b0;
    step();
    chk("midrst_gnt", bus.oGnt, 8'hFF);
    chk("midrst_valid", bus.oValid, 1'b0);
    chk("midrst_gnt_id", bus.oGntId, 3'd0);
    iRst_n = 1'b1; bus.iReq = 8'h00;
    step();
    chk("postrst_gnt_id", bus.oGntId, 3'd7);
    chk("postrst_valid", bus.oValid, 1'b1);

    // Wrap-around fairness between requesters 7 and 0.
    iRst_n = 1'b0; bus.iReq = 8'hFF;
    step();
    iRst_n = 1'b1;
    base = 8'b01111110;
    bus.iReq = base;
    for (int i = 0; i < 4; i++) begin
      wait_grant(gid);
      chk("fair_seq", gid, exp_seq[i]);
      bus.iReq = base | (8'd1 << gid);
      step();
      bus.iReq = base;
    end

    // Single requester holding for a long time.
    iRst_n = 1'b0; bus.iReq = 8'hFF;
    step();
    iRst_n = 1'b1; bus.iReq = 8'b11111110;
    wait_grant(gid);
    chk("hold_gnt_id", gid, 0);
    run = 0; touts = 0; tout_at = -1; broken = 1'b0; regrant = 1'b0;
    for (int s = 0; s < 22; s++) begin
      if (!broken && bus.oValid && bus.oGnt == 8'b11111110) run++;
      else broken = 1'b1;
      if (bus.oTimeout) begin touts++; tout_at = s; end
      if (broken && bus.oValid && bus.oGntId == 3'd0) regrant = 1'b1;
      step();
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_run", run, 16);
    chk("hold_touts", touts, 1);
    chk("hold_tout_at", tout_at, 16);
    chk("hold_regrant", regrant, 1'b1);
`else
    chk("hold_run", run, 22);
    chk("hold_touts", touts, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
